// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: access-size encodings, default widths and
// the alignment rule used by the memory stage.
package mips_pkg;

   localparam int NBITS_DEF = 32;
   localparam int REGS_DEF  = 5;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b11;

   // 2'b10 is not a legal encoding and is handled as a full word.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      logic mis;
      case (size)
         SZ_BYTE: mis = 1'b0;
         SZ_HALF: mis = off[0];
         default: mis = (off != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/etapa_mem_wb_data_memory.sv
// Word-organised data memory: byte-enable write, read-first registered read and
// a free-running registered debug read; both read registers clear on reset.
module data_memory #(
   parameter int NBITS     = 32,
   parameter int MEM_WORDS = 256,
   parameter int ADDR_W    = $clog2(MEM_WORDS),
   parameter int LANES     = NBITS / 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_we,
   input  logic [LANES-1:0]  i_be,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [NBITS-1:0]  i_wdata,
   input  logic              i_re,
   output logic [NBITS-1:0]  o_rdata,
   input  logic [ADDR_W-1:0] i_dbg_addr,
   output logic [NBITS-1:0]  o_dbg_data
);

   logic [NBITS-1:0] mem [MEM_WORDS];

   // Array storage carries no reset; the caller qualifies i_we with reset.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         for (int l = 0; l < LANES; l++) begin
            if (i_be[l]) mem[i_addr][8*l +: 8] <= i_wdata[8*l +: 8];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) o_rdata <= '0;
      else if (i_re) o_rdata <= mem[i_addr];
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) o_dbg_data <= '0;
      else o_dbg_data <= mem[i_dbg_addr];
   end

endmodule

// File: rtl/etapa_mem_wb.sv
// MIPS MEM stage plus MEM/WB register: branch resolve, sized store/load, one-cycle
// latency to WB; i_enable low freezes every register except the debug read.
module etapa_mem_wb
   import mips_pkg::*;
#(
   parameter int NBITS     = NBITS_DEF,
   parameter int REGS      = REGS_DEF,
   parameter int MEM_WORDS = 256,
   parameter int ADDR_W    = $clog2(MEM_WORDS)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_enable,
   input  logic [NBITS-1:0]  i_ALU,
   input  logic [NBITS-1:0]  i_Registro2,
   input  logic              i_Cero,
   input  logic [REGS-1:0]   i_RegistroDestino,
   input  logic [NBITS-1:0]  i_PC8,
   input  logic [NBITS-1:0]  i_Extension,
   input  logic              i_Branch,
   input  logic              i_NBranch,
   input  logic              i_MemWrite,
   input  logic              i_MemRead,
   input  logic [1:0]        i_TamanoFiltro,
   input  logic              i_ZeroExtend,
   input  logic              i_MemToReg,
   input  logic              i_RegWrite,
   input  logic              i_JAL,
   input  logic              i_LUI,
   output logic              o_PCSrc,
   output logic [NBITS-1:0]  o_ReadData,
   output logic [NBITS-1:0]  o_ALU,
   output logic [NBITS-1:0]  o_PC8,
   output logic [NBITS-1:0]  o_Extension,
   output logic [REGS-1:0]   o_RegistroDestino,
   output logic              o_MemToReg,
   output logic              o_RegWrite,
   output logic              o_JAL,
   output logic              o_LUI,
   output logic              o_Misaligned,
   input  logic [ADDR_W-1:0] i_dbg_addr,
   output logic [NBITS-1:0]  o_dbg_data
);

   localparam int LANES = NBITS / 8;

   logic [1:0]        off;
   logic [ADDR_W-1:0] word_idx;
   logic              mis;
   logic [LANES-1:0]  be;
   logic [NBITS-1:0]  wdata;
   logic              we;
   logic [NBITS-1:0]  mem_rdata;

   logic              rd_vld_q;
   logic [1:0]        off_q;
   logic [1:0]        size_q;
   logic              zext_q;

   assign o_PCSrc  = (i_Branch & i_Cero) | (i_NBranch & ~i_Cero);
   assign off      = i_ALU[1:0];
   assign word_idx = i_ALU[ADDR_W+1:2];
   assign mis      = is_misaligned(i_TamanoFiltro, off);
   assign we       = i_rst_n & i_enable & i_MemWrite & ~mis;

   // Store data is replicated across lanes so the byte enables alone pick the target.
   always_comb begin
      be    = '1;
      wdata = i_Registro2;
      case (i_TamanoFiltro)
         SZ_BYTE: begin
            be    = LANES'(1) << off;
            wdata = {LANES{i_Registro2[7:0]}};
         end
         SZ_HALF: begin
            be    = LANES'(2'b11) << {off[1], 1'b0};
            wdata = {(LANES/2){i_Registro2[15:0]}};
         end
         default: begin
            be    = '1;
            wdata = i_Registro2;
         end
      endcase
   end

   data_memory #(
      .NBITS     (NBITS),
      .MEM_WORDS (MEM_WORDS),
      .ADDR_W    (ADDR_W),
      .LANES     (LANES)
   ) u_data_memory (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_we       (we),
      .i_be       (be),
      .i_addr     (word_idx),
      .i_wdata    (wdata),
      .i_re       (i_enable),
      .o_rdata    (mem_rdata),
      .i_dbg_addr (i_dbg_addr),
      .o_dbg_data (o_dbg_data)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_ALU             <= '0;
         o_PC8             <= '0;
         o_Extension       <= '0;
         o_RegistroDestino <= '0;
         o_MemToReg        <= 1'b0;
         o_RegWrite        <= 1'b0;
         o_JAL             <= 1'b0;
         o_LUI             <= 1'b0;
         o_Misaligned      <= 1'b0;
         rd_vld_q          <= 1'b0;
         off_q             <= 2'b00;
         size_q            <= 2'b00;
         zext_q            <= 1'b0;
      end else if (i_enable) begin
         o_ALU             <= i_ALU;
         o_PC8             <= i_PC8;
         o_Extension       <= i_Extension;
         o_RegistroDestino <= i_RegistroDestino;
         o_MemToReg        <= i_MemToReg;
         o_RegWrite        <= i_RegWrite;
         o_JAL             <= i_JAL;
         o_LUI             <= i_LUI;
         o_Misaligned      <= mis & (i_MemRead | i_MemWrite);
         rd_vld_q          <= i_MemRead & ~mis;
         off_q             <= off;
         size_q            <= i_TamanoFiltro;
         zext_q            <= i_ZeroExtend;
      end
   end

   // Load filter works on the registered word so it stays stable across stalls.
   always_comb begin
      logic [7:0]  byte_sel;
      logic [15:0] half_sel;
      byte_sel   = mem_rdata[{off_q, 3'b000} +: 8];
      half_sel   = mem_rdata[{off_q[1], 4'b0000} +: 16];
      o_ReadData = '0;
      if (rd_vld_q) begin
         case (size_q)
            SZ_BYTE: o_ReadData = {{(NBITS-8){byte_sel[7] & ~zext_q}}, byte_sel};
            SZ_HALF: o_ReadData = {{(NBITS-16){half_sel[15] & ~zext_q}}, half_sel};
            default: o_ReadData = mem_rdata;
         endcase
      end
   end

endmodule

// File: tb/tb_etapa_mem_wb.sv
// Scoreboard bench for etapa_mem_wb: a driver pushes model predictions, a monitor
// pops one per clock and compares the MEM/WB outputs and the debug read.
module tb_etapa_mem_wb;

   localparam int MW = 256;
   localparam int AW = 8;

   logic        i_clk, i_rst_n, i_enable;
   logic [31:0] i_ALU, i_Registro2, i_PC8, i_Extension;
   logic        i_Cero, i_Branch, i_NBranch, i_MemWrite, i_MemRead, i_ZeroExtend;
   logic        i_MemToReg, i_RegWrite, i_JAL, i_LUI;
   logic [4:0]  i_RegistroDestino;
   logic [1:0]  i_TamanoFiltro;
   logic [AW-1:0] i_dbg_addr;
   logic        o_PCSrc, o_MemToReg, o_RegWrite, o_JAL, o_LUI, o_Misaligned;
   logic [31:0] o_ReadData, o_ALU, o_PC8, o_Extension, o_dbg_data;
   logic [4:0]  o_RegistroDestino;

   etapa_mem_wb dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_ALU(i_ALU),
      .i_Registro2(i_Registro2), .i_Cero(i_Cero), .i_RegistroDestino(i_RegistroDestino),
      .i_PC8(i_PC8), .i_Extension(i_Extension), .i_Branch(i_Branch), .i_NBranch(i_NBranch),
      .i_MemWrite(i_MemWrite), .i_MemRead(i_MemRead), .i_TamanoFiltro(i_TamanoFiltro),
      .i_ZeroExtend(i_ZeroExtend), .i_MemToReg(i_MemToReg), .i_RegWrite(i_RegWrite),
      .i_JAL(i_JAL), .i_LUI(i_LUI), .o_PCSrc(o_PCSrc), .o_ReadData(o_ReadData),
      .o_ALU(o_ALU), .o_PC8(o_PC8), .o_Extension(o_Extension),
      .o_RegistroDestino(o_RegistroDestino), .o_MemToReg(o_MemToReg),
      .o_RegWrite(o_RegWrite), .o_JAL(o_JAL), .o_LUI(o_LUI), .o_Misaligned(o_Misaligned),
      .i_dbg_addr(i_dbg_addr), .o_dbg_data(o_dbg_data)
   );

   typedef struct {
      logic en, br, nbr, cero, mw, mr, zx, m2r, rw, jal, lui;
      logic [1:0] sz;
      logic [31:0] alu, r2, pc8, ext;
      logic [4:0] rd;
      logic [7:0] dbg;
   } stim_t;

   typedef struct {
      logic [31:0] alu, pc8, ext, rdata;
      logic [4:0]  rd;
      logic        m2r, rw, jal, lui, mis;
      logic        dbg_ok;
      logic [31:0] dbg;
   } exp_t;

   exp_t        sbq[$];
   exp_t        prev;
   logic [31:0] mm[MW];
   bit          known[MW];
   int          tests = 0;
   int          fails = 0;
   bit          have = 0;

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] sz,
                                            input int off, input logic zx);
      logic [31:0] v;
      if (sz == 2'b00) begin
         v = (w >> (8 * off)) & 32'hFF;
         if (!zx && v >= 128) v = v - 256;
      end else if (sz == 2'b01) begin
         v = (w >> (16 * (off / 2))) & 32'hFFFF;
         if (!zx && v >= 32768) v = v - 65536;
      end else begin
         v = w;
      end
      return v;
   endfunction

   function automatic bit bad_align(input logic [1:0] sz, input int off);
      if (sz == 2'b00) return 1'b0;
      if (sz == 2'b01) return (off % 2) != 0;
      return off != 0;
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s.en = 1'b1; s.br = 1'b0; s.nbr = 1'b0; s.cero = 1'($urandom);
      s.mw = 1'b0; s.mr = 1'b0; s.zx = 1'b0; s.sz = 2'b11;
      s.m2r = 1'($urandom); s.rw = 1'($urandom); s.jal = 1'($urandom); s.lui = 1'($urandom);
      s.alu = $urandom; s.r2 = $urandom; s.pc8 = $urandom; s.ext = $urandom;
      s.rd = 5'($urandom); s.dbg = 8'd0;
      return s;
   endfunction

   task automatic drive(input stim_t s);
      i_enable = s.en; i_Branch = s.br; i_NBranch = s.nbr; i_Cero = s.cero;
      i_MemWrite = s.mw; i_MemRead = s.mr; i_ZeroExtend = s.zx; i_TamanoFiltro = s.sz;
      i_MemToReg = s.m2r; i_RegWrite = s.rw; i_JAL = s.jal; i_LUI = s.lui;
      i_ALU = s.alu; i_Registro2 = s.r2; i_PC8 = s.pc8; i_Extension = s.ext;
      i_RegistroDestino = s.rd; i_dbg_addr = s.dbg;
   endtask

   // One clock of stimulus; the prediction covers the edge that consumes it.
   task automatic apply(input stim_t s);
      exp_t e;
      int   idx, off, src;
      bit   mis;
      logic pc_exp;
      @(posedge i_clk);
      #2;
      drive(s);
      e = prev;
      e.dbg_ok = known[s.dbg];
      e.dbg    = mm[s.dbg];
      if (s.en) begin
         idx = int'((s.alu / 4) % MW);
         off = int'(s.alu % 4);
         mis = bad_align(s.sz, off);
         e.alu = s.alu; e.pc8 = s.pc8; e.ext = s.ext; e.rd = s.rd;
         e.m2r = s.m2r; e.rw = s.rw; e.jal = s.jal; e.lui = s.lui;
         e.mis   = mis && (s.mr || s.mw);
         e.rdata = (s.mr && !mis) ? load_val(mm[idx], s.sz, off, s.zx) : 32'd0;
         if (s.mw && !mis) begin
            for (int b = 0; b < 4; b++) begin
               src = -1;
               if (s.sz == 2'b00 && b == off) src = 0;
               else if (s.sz == 2'b01 && (b == off || b == off + 1)) src = b - off;
               else if (s.sz[1]) src = b;
               if (src >= 0)
                  mm[idx] = (mm[idx] & ~(32'hFF << (8 * b))) |
                            (((s.r2 >> (8 * src)) & 32'hFF) << (8 * b));
            end
            if (s.sz[1]) known[idx] = 1'b1;
         end
      end
      prev = e;
      sbq.push_back(e);
      #1;
      pc_exp = (s.br && s.cero) || (s.nbr && !s.cero);
      tests++;
      if (o_PCSrc !== pc_exp) begin
         fails++;
         $display("FAIL pcsrc got %b want %b (br=%b nbr=%b cero=%b en=%b)",
                  o_PCSrc, pc_exp, s.br, s.nbr, s.cero, s.en);
      end
   endtask

   // Reset with a live store on the bus: memory must not change, outputs must clear.
   task automatic do_reset(input int addr);
      stim_t s;
      s = idle();
      s.mw = 1'b1; s.sz = 2'b11; s.alu = 32'(addr); s.rw = 1'b1; s.dbg = 8'(addr / 4);
      @(posedge i_clk);
      #2;
      drive(s);
      i_rst_n = 1'b0;
      repeat (3) begin
         @(negedge i_clk);
         tests++;
         if ({o_ALU, o_PC8, o_Extension, o_ReadData, o_dbg_data, o_RegistroDestino,
              o_MemToReg, o_RegWrite, o_JAL, o_LUI, o_Misaligned} !== '0) begin
            fails++;
            $display("FAIL reset_outputs got alu=%h rd=%h dbg=%h rw=%b mis=%b want all 0",
                     o_ALU, o_ReadData, o_dbg_data, o_RegWrite, o_Misaligned);
         end
      end
      @(posedge i_clk);
      #2;
      i_enable = 1'b0;
      i_rst_n  = 1'b1;
      prev = '{alu: 0, pc8: 0, ext: 0, rdata: 0, rd: 0, m2r: 0, rw: 0, jal: 0, lui: 0,
               mis: 0, dbg_ok: 0, dbg: 0};
   endtask

   always @(posedge i_clk) have = (sbq.size() != 0);

   always @(negedge i_clk) begin
      exp_t e;
      if (have) begin
         e = sbq.pop_front();
         tests++;
         if ({o_ALU, o_PC8, o_Extension, o_ReadData, o_RegistroDestino,
              o_MemToReg, o_RegWrite, o_JAL, o_LUI, o_Misaligned} !==
             {e.alu, e.pc8, e.ext, e.rdata, e.rd, e.m2r, e.rw, e.jal, e.lui, e.mis}) begin
            fails++;
            $display("FAIL memwb got alu=%h pc8=%h ext=%h rdata=%h rd=%0d ctl=%b%b%b%b mis=%b want alu=%h pc8=%h ext=%h rdata=%h rd=%0d ctl=%b%b%b%b mis=%b",
                     o_ALU, o_PC8, o_Extension, o_ReadData, o_RegistroDestino, o_MemToReg,
                     o_RegWrite, o_JAL, o_LUI, o_Misaligned, e.alu, e.pc8, e.ext, e.rdata,
                     e.rd, e.m2r, e.rw, e.jal, e.lui, e.mis);
         end
         if (e.dbg_ok) begin
            tests++;
            if (o_dbg_data !== e.dbg) begin
               fails++;
               $display("FAIL dbg got %h want %h", o_dbg_data, e.dbg);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      fails++;
      $display("FAIL timeout simulation did not finish");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "timeout");
   end

   initial begin
      stim_t s;
      logic [31:0] ld_addr[4] = '{32'h23, 32'h23, 32'h22, 32'h21};
      logic [1:0]  ld_sz[4]   = '{2'b00, 2'b00, 2'b01, 2'b00};
      logic        ld_zx[4]   = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [2:0]  br_tab[3]  = '{3'b101, 3'b011, 3'b010};
      int idx, off;

      for (int i = 0; i < MW; i++) begin mm[i] = 32'd0; known[i] = 1'b0; end
      i_rst_n = 1'b0;
      drive(idle());
      do_reset(32'h14);

      for (int w = 0; w < 16; w++) begin
         s = idle(); s.mw = 1'b1; s.alu = 32'(w * 4); s.dbg = 8'(w); apply(s);
      end

      s = idle(); s.mw = 1'b1; s.alu = 32'h10; s.r2 = 32'hDEADBEEF; s.dbg = 8'd4; apply(s);
      s = idle(); s.mw = 1'b1; s.sz = 2'b00; s.alu = 32'h12; s.r2 = 32'hABCDEF55; s.dbg = 8'd4; apply(s);
      s = idle(); s.dbg = 8'd4; apply(s);
      s = idle(); s.mw = 1'b1; s.sz = 2'b01; s.alu = 32'h10; s.r2 = 32'h99991234; s.dbg = 8'd4; apply(s);
      s = idle(); s.dbg = 8'd4; apply(s);

      s = idle(); s.mw = 1'b1; s.alu = 32'h20; s.r2 = 32'h80FF7F01; s.dbg = 8'd8; apply(s);
      for (int i = 0; i < 4; i++) begin
         s = idle(); s.mr = 1'b1; s.alu = ld_addr[i]; s.sz = ld_sz[i]; s.zx = ld_zx[i];
         s.dbg = 8'd8; apply(s);
      end

      s = idle(); s.mw = 1'b1; s.alu = 32'h22; s.r2 = 32'h11111111; s.dbg = 8'd8; apply(s);
      s = idle(); s.dbg = 8'd8; apply(s);
      s = idle(); s.mr = 1'b1; s.sz = 2'b01; s.alu = 32'h21; apply(s);

      for (int en = 0; en < 2; en++) begin
         for (int i = 0; i < 3; i++) begin
            s = idle(); s.en = 1'(en); s.br = br_tab[i][2]; s.nbr = br_tab[i][1];
            s.cero = br_tab[i][0]; apply(s);
         end
      end

      s = idle(); s.en = 1'b0; s.mw = 1'b1; s.alu = 32'h24; s.r2 = 32'hCAFEF00D; s.dbg = 8'd9; apply(s);
      s = idle(); s.en = 1'b0; s.dbg = 8'd9; apply(s);
      s = idle(); s.mw = 1'b1; s.mr = 1'b1; s.alu = 32'h24; s.r2 = 32'h0BADC0DE; s.dbg = 8'd9; apply(s);
      s = idle(); s.dbg = 8'd9; apply(s);
      s = idle(); s.mr = 1'b1; s.alu = 32'h24; s.dbg = 8'd9; apply(s);

      s = idle(); s.en = 1'b0; apply(s);
      repeat (2) @(posedge i_clk);
      do_reset(32'h14);
      s = idle(); s.en = 1'b0; s.dbg = 8'd5; apply(s);
      s = idle(); s.dbg = 8'd5; apply(s);

      for (int n = 0; n < 400; n++) begin
         s = idle();
         s.en   = ($urandom % 5) != 0;
         s.mr   = 1'($urandom); s.mw = 1'($urandom); s.zx = 1'($urandom);
         s.sz   = 2'($urandom);
         s.br   = 1'($urandom); s.nbr = 1'($urandom);
         idx    = int'($urandom % 16);
         off    = int'($urandom % 4);
         s.alu  = ($urandom & 32'hFFFFFC00) | 32'(idx * 4) | 32'(off);
         s.dbg  = 8'($urandom % 16);
         apply(s);
      end

      s = idle(); s.en = 1'b0; apply(s);
      repeat (3) @(posedge i_clk);
      tests++;
      if (sbq.size() != 0) begin
         fails++;
         $display("FAIL drain got %0d pending want 0", sbq.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/etapa_mem_wb.md
Name: etapa_mem_wb

Overview:
- MEM stage of the 5-stage MIPS pipeline. Consumes the EX/MEM register outputs.
- Resolves conditional branches (PCSrc back to IF) and performs byte/half/word stores into an internal word-organised data memory. Loads go through a size filter with sign or zero extension.
- Registers everything WB needs into the MEM/WB boundary.
- Exposes a registered debug read port for memory dumps by the debug unit.

Parameters:
- NBITS, 32, datapath width
- REGS, 5, register-index width
- MEM_WORDS, 256, data memory depth in 32-bit words (power of two)
- ADDR_W, $clog2(MEM_WORDS), word-address width

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_enable  in  1  pipeline step enable (debug-unit step mode); 0 freezes all state
- i_ALU  in  NBITS  byte address for load/store; passed to WB for ALU results
- i_Registro2  in  NBITS  store data
- i_Cero  in  1  ALU zero flag
- i_RegistroDestino  in  REGS  destination register
- i_PC8  in  NBITS  link address for JAL
- i_Extension  in  NBITS  immediate for LUI
- i_Branch, i_NBranch  in  1 each  BEQ / BNE
- i_MemWrite, i_MemRead  in  1 each  store / load
- i_TamanoFiltro  in  2  access size: 00 byte, 01 half, 11 word, 10 treated as word
- i_ZeroExtend  in  1  1 = zero-extend load, 0 = sign-extend
- i_MemToReg, i_RegWrite, i_JAL, i_LUI  in  1 each  WB controls
- o_PCSrc  out  1  branch taken, combinational
- o_ReadData  out  NBITS  filtered load data, MEM/WB
- o_ALU, o_PC8, o_Extension  out  NBITS  MEM/WB copies
- o_RegistroDestino  out  REGS  MEM/WB copy
- o_MemToReg, o_RegWrite, o_JAL, o_LUI  out  1 each  MEM/WB copies
- o_Misaligned  out  1  registered flag: last enabled access was misaligned
- i_dbg_addr  in  ADDR_W  debug word address
- o_dbg_data  out  NBITS  memory word at i_dbg_addr, one cycle later

Behaviour:
- Reset, asynchronous on i_rst_n=0:
  - all MEM/WB outputs, o_Misaligned and o_dbg_data go to 0;
  - o_RegWrite=0, so a bubble is presented to WB;
  - memory contents are not reset.
- Branch resolution: o_PCSrc = (i_Branch & i_Cero) | (i_NBranch & ~i_Cero). Purely combinational and independent of i_enable.
- Addressing:
  - word index = i_ALU[ADDR_W+1:2]; upper bits are ignored and wrap modulo MEM_WORDS;
  - byte offset = i_ALU[1:0].
- Alignment:
  - half is misaligned if i_ALU[0]=1;
  - word is misaligned if i_ALU[1:0]!=0;
  - byte is never misaligned.
  - A misaligned store is suppressed (memory unchanged). A misaligned load returns 0.
  - In both cases o_Misaligned=1 on the next enabled edge. Otherwise o_Misaligned=0 on each enabled edge.
- Store, when i_enable & i_MemWrite & aligned, at the rising edge:
  - byte: lane offset gets i_Registro2[7:0];
  - half: lanes {off+1, off} get i_Registro2[15:0];
  - word: all lanes get i_Registro2.
  - Other lanes are preserved (byte-enable write).
- Load:
  - the memory word is read synchronously on the enabled edge, read-first: a simultaneous store to the same word does not affect this read;
  - offset, size and ZeroExtend are registered alongside it;
  - o_ReadData selects the byte or half at the registered offset, extends it per the registered i_ZeroExtend, and is stable until the next enabled edge;
  - if i_MemRead=0, o_ReadData=0.
- MEM/WB register: on each enabled edge, all o_* copies take their inputs. Latency is 1 cycle. With i_enable=0, all outputs hold.
- If i_MemWrite and i_MemRead are both 1 (illegal), the store takes effect and the load reads old data.
- Debug port: o_dbg_data <= mem[i_dbg_addr] every clock, regardless of i_enable. It sees stores from the previous edge or earlier.
- Reset asserted mid-operation: a store on the same edge as reset release is not performed. Storage writes are qualified by i_rst_n.

Decomposition:
- Shared package mips_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b11;
  - the NBITS/REGS defaults.
- Sub-module data_memory: word array with 4-bit byte-enable write, read-first synchronous read port, and a second synchronous read port for debug.
- Byte-enable generation, misalignment check, load filter and MEM/WB register stay in the top.

Test Plan:
- Reset: hold i_rst_n=0 with random inputs -> all outputs 0, o_RegWrite=0. Release -> first enabled edge propagates inputs.
- Word then byte/half:
  - store 0xDEADBEEF at addr 0x10;
  - byte store 0x55 at addr 0x12 -> debug read of word 4 = 0xDE55BEEF;
  - half store 0x1234 at 0x10 -> 0xDE551234.
- Loads from word 0x80FF7F01 at addr 0x20:
  - byte, offset 3, sign -> 0xFFFFFF80;
  - byte, offset 3, zero -> 0x00000080;
  - half, offset 2, sign -> 0xFFFF80FF;
  - byte, offset 1, sign -> 0x0000007F.
- Misalignment: word store at 0x22 -> memory unchanged and o_Misaligned=1. Half load at 0x21 -> o_ReadData=0 and o_Misaligned=1.
- Branch: Branch=1, Cero=1 -> o_PCSrc=1; NBranch=1, Cero=1 -> 0; NBranch=1, Cero=0 -> 1. Check all with i_enable=0 too.
- Stall: i_enable=0 with i_MemWrite=1 -> memory and all MEM/WB outputs unchanged. Read-during-write on the same word -> load returns old data, and the debug read next cycle shows the new data.
